t07_mem_arbiter: RTL



---
 rtl/t07_mem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/t07_mem_arbiter.sv
// t07_mem_arbiter
//   Shares one busy-handshaked external memory bus among NCH requesters
//   (fetch, load/store, FPU load/store, ...). The request/grant FSM is
//   registered. Arbitration is fixed priority (lowest index wins) or
//   round-robin, selected by RR_MODE.
//
// Ports
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   req_i        per-channel request, held until that channel's done_o
//   we_i         per-channel write enable
//   inst_i       per-channel instruction-fetch flag (ignored when we_i=1)
//   addr_i       flattened addresses, channel k at [k*AW +: AW]
//   wdata_i      flattened write data, same packing
//   rdata_o      data of the last completed read (writes leave it alone)
//   done_o       one-cycle, one-hot completion pulse
//   freeze_o     per-channel stall: req_i & ~done_o
//   ext_addr_o   address latched at grant
//   ext_wdata_o  write data latched at grant
//   ext_rdata_i  external read data, sampled when busy falls
//   ext_busy_i   external memory busy
//   rwi_o        bus command: 00 idle, 01 fetch, 10 read, 11 write
//   busy_edge_o  registered busy falling-edge detect
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | bus free; arbitrate and latch the winner's transaction
// ST_ISSUE | command on rwi_o, waiting for the memory to raise busy
// ST_WAIT  | command on rwi_o, waiting for busy to fall
// ST_DONE  | rwi_o idle, done_o pulses for the granted channel

module t07_mem_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH-1:0]    we_i,
  input  logic [NCH-1:0]    inst_i,
  input  logic [NCH*AW-1:0] addr_i,
  input  logic [NCH*DW-1:0] wdata_i,
  output logic [DW-1:0]     rdata_o,
  output logic [NCH-1:0]    done_o,
  output logic [NCH-1:0]    freeze_o,
  output logic [AW-1:0]     ext_addr_o,
  output logic [DW-1:0]     ext_wdata_o,
  input  logic [DW-1:0]     ext_rdata_i,
  input  logic              ext_busy_i,
  output logic [1:0]        rwi_o,
  output logic              busy_edge_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_FETCH = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_nxt;
  logic [1:0]    cmd_q;
  logic          busy_q;

  logic [IW-1:0] arb_idx;
  logic          arb_found;
  logic [1:0]    arb_cmd;
  int            arb_c;
  logic [NCH-1:0] req_rot;

  logic          grant_now;
  logic          busy_fall;

  logic [AW-1:0] addr_a  [NCH];
  logic [DW-1:0] wdata_a [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign addr_a[k]  = addr_i[k*AW +: AW];
    assign wdata_a[k] = wdata_i[k*DW +: DW];
  end

  // Scan channels starting at 0 (fixed) or at ptr_q (round-robin),
  // wrapping at NCH; the first requesting channel found wins.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    arb_c     = 0;
    req_rot   = '0;
    for (int i = 0; i < NCH; i++) begin
      arb_c = (RR_MODE != 0) ? (int'(ptr_q) + i) : i;
      if (arb_c >= NCH) begin
        arb_c = arb_c - NCH;
      end
      req_rot = req_i >> arb_c;
      if (!arb_found && req_rot[0]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(arb_c);
      end
    end
  end

  assign ptr_nxt = (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + IW'(1);

  // A write wins over the fetch flag.
  always_comb begin
    if (we_i[arb_idx]) begin
      arb_cmd = CMD_WRITE;
    end else if (inst_i[arb_idx]) begin
      arb_cmd = CMD_FETCH;
    end else begin
      arb_cmd = CMD_READ;
    end
  end

  assign grant_now = (state_q == ST_IDLE) && arb_found;
  assign busy_fall = busy_q && !ext_busy_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_found)  state_d = ST_ISSUE;
      ST_ISSUE: if (ext_busy_i) state_d = ST_WAIT;
      ST_WAIT:  if (busy_fall)  state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      busy_edge_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= ext_busy_i;
      busy_edge_o <= busy_fall;
    end
  end

  // Transaction context is captured only at grant, so requesters may
  // change their inputs (or drop req_i) once granted without effect.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant_q     <= '0;
      ptr_q       <= '0;
      cmd_q       <= CMD_IDLE;
      ext_addr_o  <= '0;
      ext_wdata_o <= '0;
    end else if (grant_now) begin
      grant_q     <= arb_idx;
      ptr_q       <= ptr_nxt;
      cmd_q       <= arb_cmd;
      ext_addr_o  <= addr_a[arb_idx];
      ext_wdata_o <= wdata_a[arb_idx];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata_o <= '0;
    end else if ((state_q == ST_WAIT) && busy_fall && (cmd_q != CMD_WRITE)) begin
      rdata_o <= ext_rdata_i;
    end
  end

  assign rwi_o = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? cmd_q : CMD_IDLE;

  always_comb begin
    done_o = '0;
    if (state_q == ST_DONE) begin
      done_o[grant_q] = 1'b1;
    end
  end

  assign freeze_o = req_i & ~done_o;

endmodule
